// File: rtl/alsu_pkg.sv
// Purpose : shared opcode constants, FSM state encoding and the invalid-op rule for the ALSU.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package alsu_pkg;

   localparam logic [2:0] OP_OR     = 3'd0;
   localparam logic [2:0] OP_XOR    = 3'd1;
   localparam logic [2:0] OP_ADD    = 3'd2;
   localparam logic [2:0] OP_MUL    = 3'd3;
   localparam logic [2:0] OP_SHIFT  = 3'd4;
   localparam logic [2:0] OP_ROTATE = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2
   } state_t;

   // Opcodes 6/7 do not exist; reductions are only defined for OR/XOR.
   function automatic logic is_invalid(input logic [2:0] op, input logic red_a, input logic red_b);
      return (op == 3'd6) || (op == 3'd7) || ((red_a | red_b) && (op[2:1] != 2'b00));
   endfunction

endpackage

// File: rtl/alsu_seq_mult.sv
// Purpose : iterative shift-add multiplier, one multiplier bit consumed per clock.
// Latency : start edge loads operands; done is high during the WIDTH-th cycle with the full product.
// Backpr. : none; a new start reloads and abandons any product in progress.
// Ports   : clk, rst (async, active-high), start, A, B in; done, product out.
module alsu_seq_mult
   import alsu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);
   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [WIDTH-1:0]   mplier_q;
   logic [CW-1:0]      cnt_q;
   logic               busy_q;

   // Product is exposed combinationally so the caller can capture it on the
   // same edge that would retire the last bit.
   assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign product = acc_d;
   assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start) begin
         mcand_q  <= {{WIDTH{1'b0}}, A};
         acc_q    <= '0;
         mplier_q <= B;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         acc_q    <= acc_d;
         mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
         mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
         cnt_q    <= cnt_q + CW'(1);
         if (done) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alsu_gen.sv
// Purpose : arithmetic/logic/shift unit with reductions, bypass, sequential multiply and error-blink leds.
// Latency : out/out_valid one edge after acceptance; multiply WIDTH edges after acceptance.
// Backpr. : in_ready high only in IDLE; in_valid while busy is dropped, never queued.
// Ports   : clk, rst; in_valid/in_ready handshake; A, B, cin, serial_in, red_op_A/B, bypass_A/B,
//           direction, opcode in; out (2*WIDTH), out_valid, invalid_op, leds (LED_WIDTH) out.
module alsu_gen
   import alsu_pkg::*;
#(
   parameter int    WIDTH          = 8,
   parameter string INPUT_PRIORITY = "A",
   parameter string FULL_ADDER     = "ON",
   parameter int    LED_WIDTH      = 16,
   parameter int    BLINK_DIV      = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 cin,
   input  logic                 serial_in,
   input  logic                 red_op_A,
   input  logic                 red_op_B,
   input  logic                 bypass_A,
   input  logic                 bypass_B,
   input  logic                 direction,
   input  logic [2:0]           opcode,
   output logic [2*WIDTH-1:0]   out,
   output logic                 out_valid,
   output logic                 invalid_op,
   output logic [LED_WIDTH-1:0] leds
);
   localparam bit PRIO_B  = (INPUT_PRIORITY == "B");
   localparam bit USE_CIN = (FULL_ADDER == "ON");
   localparam int BW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   state_t               state_q, state_d;
   logic                 accept, go_mul, mul_start, mul_done;
   logic                 exec_done, mul_fin, done_any, done_inv, op_invalid;
   logic [2*WIDTH-1:0]   mul_product, result;
   logic [WIDTH-1:0]     a_q, b_q, red_src;
   logic                 cin_q, sin_q, red_a_q, red_b_q, byp_a_q, byp_b_q, dir_q;
   logic [2:0]           op_q;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   out_q, out_d;
   logic                 out_valid_q, out_valid_d, invalid_op_q, invalid_op_d;
   logic [LED_WIDTH-1:0] leds_q, leds_d;
   logic                 blink_q, blink_d;
   logic [BW-1:0]        blink_cnt_q, blink_cnt_d;

   assign in_ready   = (state_q == ST_IDLE);
   assign accept     = in_valid && in_ready;
   // Only a genuine multiply takes the long path; invalid or bypassed opcode 3 finishes in EXEC.
   assign go_mul     = (opcode == OP_MUL) && !is_invalid(opcode, red_op_A, red_op_B)
                       && !bypass_A && !bypass_B;
   assign mul_start  = accept && go_mul;
   assign op_invalid = is_invalid(op_q, red_a_q, red_b_q);
   assign exec_done  = (state_q == ST_EXEC);
   assign mul_fin    = (state_q == ST_MUL) && mul_done;
   assign done_any   = exec_done || mul_fin;
   assign done_inv   = exec_done && op_invalid;

   assign out        = out_q;
   assign out_valid  = out_valid_q;
   assign invalid_op = invalid_op_q;
   assign leds       = leds_q;

   alsu_seq_mult #(.WIDTH(WIDTH)) u_mult (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .A       (A),
      .B       (B),
      .done    (mul_done),
      .product (mul_product)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = go_mul ? ST_MUL : ST_EXEC;
         ST_EXEC: state_d = ST_IDLE;
         ST_MUL:  if (mul_done) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Single-cycle result from the registered request.
   always_comb begin
      result  = '0;
      red_src = (red_a_q && red_b_q) ? (PRIO_B ? b_q : a_q) : (red_a_q ? a_q : b_q);
      sum     = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q & USE_CIN};
      if (op_invalid) begin
         result = '0;
      end else if (byp_a_q && byp_b_q) begin
         result = {{WIDTH{1'b0}}, (PRIO_B ? b_q : a_q)};
      end else if (byp_a_q) begin
         result = {{WIDTH{1'b0}}, a_q};
      end else if (byp_b_q) begin
         result = {{WIDTH{1'b0}}, b_q};
      end else begin
         case (op_q)
            OP_OR:     result = (red_a_q || red_b_q) ? {{(2*WIDTH-1){1'b0}}, |red_src}
                                                     : {{WIDTH{1'b0}}, a_q | b_q};
            OP_XOR:    result = (red_a_q || red_b_q) ? {{(2*WIDTH-1){1'b0}}, ^red_src}
                                                     : {{WIDTH{1'b0}}, a_q ^ b_q};
            OP_ADD:    result = {{(WIDTH-1){1'b0}}, sum};
            OP_SHIFT:  result = dir_q ? {out_q[2*WIDTH-2:0], sin_q} : {sin_q, out_q[2*WIDTH-1:1]};
            OP_ROTATE: result = dir_q ? {out_q[2*WIDTH-2:0], out_q[2*WIDTH-1]}
                                      : {out_q[0], out_q[2*WIDTH-1:1]};
            default:   result = '0;
         endcase
      end
   end

   // out holds through MUL and only moves on a completion edge.
   always_comb begin
      out_d        = out_q;
      out_valid_d  = done_any;
      invalid_op_d = done_inv;
      leds_d       = leds_q;
      blink_d      = blink_q;
      blink_cnt_d  = blink_cnt_q;
      if (exec_done)    out_d = result;
      else if (mul_fin) out_d = mul_product;
      // A good completion clears the blink; a repeat invalid keeps the running divider.
      if (done_any && !done_inv) begin
         leds_d      = '0;
         blink_d     = 1'b0;
         blink_cnt_d = '0;
      end else if (blink_q) begin
         if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            leds_d      = ~leds_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
         end
      end else if (done_inv) begin
         blink_d     = 1'b1;
         blink_cnt_d = '0;
         leds_d      = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q <= '0; b_q <= '0; op_q <= '0;
         cin_q <= 1'b0; sin_q <= 1'b0; red_a_q <= 1'b0; red_b_q <= 1'b0;
         byp_a_q <= 1'b0; byp_b_q <= 1'b0; dir_q <= 1'b0;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         invalid_op_q <= 1'b0;
         leds_q       <= '0;
         blink_q      <= 1'b0;
         blink_cnt_q  <= '0;
      end else begin
         if (accept) begin
            a_q <= A; b_q <= B; op_q <= opcode;
            cin_q <= cin; sin_q <= serial_in; red_a_q <= red_op_A; red_b_q <= red_op_B;
            byp_a_q <= bypass_A; byp_b_q <= bypass_B; dir_q <= direction;
         end
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         invalid_op_q <= invalid_op_d;
         leds_q       <= leds_d;
         blink_q      <= blink_d;
         blink_cnt_q  <= blink_cnt_d;
      end
   end

endmodule

// File: doc/alsu_gen.md
ALSU_GEN -- requirements
Module: alsu_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width (2..16).
REQ-002 SHALL have parameter INPUT_PRIORITY, default "A", operand chosen when both bypass or both red_op flags are set ("A" or "B").
REQ-003 SHALL have parameter FULL_ADDER, default "ON", adds cin_reg when "ON".
REQ-004 SHALL have parameter LED_WIDTH, default 16, leds bus width.
REQ-005 SHALL have parameter BLINK_DIV, default 4, clock cycles per leds toggle (>=1).
REQ-006 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports in_valid in 1 / in_ready out 1, the operation-request handshake.
REQ-009 SHALL have ports A, B  in  WIDTH  operands.
REQ-010 SHALL have 1-bit inputs cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction, plus opcode in 3.
REQ-011 SHALL have ports out out 2*WIDTH result register, out_valid out 1 one-cycle result strobe, invalid_op out 1 strobe coincident with out_valid.
REQ-012 SHALL have port leds  out  LED_WIDTH  error blink pattern.

Function
REQ-013 FSM SHALL be IDLE -> EXEC -> IDLE; opcode 3 SHALL use IDLE -> MUL -> IDLE.
REQ-014 in_ready SHALL be 1 only in IDLE; all inputs SHALL be registered on the edge where in_valid && in_ready.
REQ-015 A non-multiply result SHALL update out, with out_valid=1, one edge after acceptance, so throughput is one op per 2 cycles.
REQ-016 invalid SHALL be: opcode 6 or 7, or (red_op_A|red_op_B) with opcode[2:1]!=0.
REQ-017 An invalid op SHALL set out=0 and pulse out_valid and invalid_op.
REQ-018 Priority SHALL be: invalid, then both bypass (INPUT_PRIORITY), then bypass_A, then bypass_B, then the opcode.
REQ-019 Opcode 0 SHALL give A|B, opcode 1 A^B; a reduction (|X or ^X) SHALL replace it when a red_op flag is set, with a 1-bit result zero-extended.
REQ-020 Opcode 2 SHALL give A+B(+cin), zero-extended to 2*WIDTH with the carry kept in bit WIDTH.
REQ-021 Opcode 3 SHALL use an iterative shift-add multiplier, one bit per cycle, and SHALL produce full A*B with out_valid exactly WIDTH edges after acceptance.
REQ-022 out SHALL hold its value during MUL and SHALL update only on the final edge.
REQ-023 Opcode 4 SHALL shift the existing out by one: direction=1 gives {out[2W-2:0],serial_in}, direction=0 gives {serial_in,out[2W-1:1]}.
REQ-024 Opcode 5 SHALL rotate out by one in the same directions, using bit wrap-around.
REQ-025 Bypass SHALL give the operand zero-extended.
REQ-026 After an invalid op, leds SHALL toggle (all bits) every BLINK_DIV cycles until the next valid op completes, then SHALL go to 0 on that completion edge.
REQ-027 A second invalid op while blinking SHALL NOT restart the divider.
REQ-028 in_valid while busy SHALL be ignored and not queued; inputs SHALL be sampled only on acceptance.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, out=0, out_valid=0, invalid_op=0, leds=0, blink counter=0, and all input registers to 0.
REQ-030 Reset mid-MUL SHALL abort with no out_valid; in_ready SHALL be 1 on the first cycle after release.

Structure
REQ-031 Package alsu_pkg SHALL hold the opcode constants (OR, XOR, ADD, MUL, SHIFT, ROTATE) and the FSM state encoding.
REQ-032 The multiplier SHALL be sub-module alsu_seq_mult (start, A, B -> done, product), the only sub-module.

Verification
REQ-033 A bench SHALL check WIDTH=8, opcode 2, A=200, B=100, cin=1 -> out=301, out_valid one edge after acceptance.
REQ-034 A bench SHALL check opcode 3, A=255, B=255 -> out=65025, out_valid 8 edges after acceptance, and in_ready=0 throughout.
REQ-035 A bench SHALL check opcode 6 -> out=0 and invalid_op=1; then leds=16'hFFFF after 4 cycles and 16'h0000 after 8; a valid opcode 0 then clears leds to 0.
REQ-036 A bench SHALL check out=16'h8001, opcode 5, direction=1 -> 16'h0003; direction=0 -> 16'hC000.
REQ-037 A bench SHALL check both bypass set with INPUT_PRIORITY="B", B=8'h5A -> out=16'h005A.
REQ-038 A bench SHALL check rst asserted 3 cycles into MUL -> no out_valid, out=0, and in_ready=1 after release.
